// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, S-box table and controller state type
//
// Purpose: width constants, the FIPS-197 forward S-box and the controller FSM
// state enum used by the shared S-box controller and its lane.
// Ports: none (package).
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_PASS = 2'd1,
        KW_PASS = 2'd2
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sbox_share_ctrl_if.sv
// rtl/sbox_share_ctrl_if.sv - request/response bundle of the shared S-box controller
//
// Purpose: groups the state and key-word request handshakes, the result
// pulses/data and the busy flag.
// master: requester side (drives st_valid/st_data/kw_valid/kw_data).
// slave : controller side (drives readies, results and busy).
interface sbox_share_ctrl_if;

    logic                         st_valid;
    logic                         st_ready;
    logic [aes_pkg::STATE_W-1:0]  st_data;
    logic                         kw_valid;
    logic                         kw_ready;
    logic [aes_pkg::WORD_W-1:0]   kw_data;
    logic                         st_out_valid;
    logic [aes_pkg::STATE_W-1:0]  st_out_data;
    logic                         kw_out_valid;
    logic [aes_pkg::WORD_W-1:0]   kw_out_data;
    logic                         busy;

    modport master (
        output st_valid, st_data, kw_valid, kw_data,
        input  st_ready, kw_ready, st_out_valid, st_out_data,
               kw_out_valid, kw_out_data, busy
    );

    modport slave (
        input  st_valid, st_data, kw_valid, kw_data,
        output st_ready, kw_ready, st_out_valid, st_out_data,
               kw_out_valid, kw_out_data, busy
    );

endinterface

// File: rtl/sbox_lane32.sv
// rtl/sbox_lane32.sv - one 32-bit lane of four forward AES S-boxes
//
// Purpose: combinational byte-wise SubWord using the aes_pkg table.
// Ports: word_i (32-bit in), word_o (32-bit substituted out).
module sbox_lane32
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// rtl/sbox_share_ctrl.sv - round-robin sharing of one S-box lane between SubBytes and SubWord
//
// Purpose: a 128-bit state is substituted one word per cycle (4 cycles) and
// a 32-bit key word in one cycle, both through a single sbox_lane32.
// Ports: clk, rst (sync active-high), bus (sbox_share_ctrl_if.slave).
module sbox_share_ctrl
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    sbox_share_ctrl_if.slave        bus
);

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 last_kw_q, last_kw_d;   // 1: key word was granted last
    logic [STATE_W-1:0]   st_cap_q, st_cap_d;
    logic [WORD_W-1:0]    kw_cap_q, kw_cap_d;
    logic [STATE_W-1:0]   st_out_q, st_out_d;
    logic [WORD_W-1:0]    kw_out_q, kw_out_d;
    logic                 st_ov_q, st_ov_d;
    logic                 kw_ov_q, kw_ov_d;
    logic                 grant_st, grant_kw;
    logic [WORD_W-1:0]    lane_in, lane_out;

    sbox_lane32 u_lane (
        .word_i (lane_in),
        .word_o (lane_out)
    );

    // Word 0 is the most significant word of the captured state.
    always_comb begin
        lane_in = kw_cap_q;
        if (state_q == ST_PASS) begin
            unique case (cnt_q)
                2'd0: lane_in = st_cap_q[127:96];
                2'd1: lane_in = st_cap_q[95:64];
                2'd2: lane_in = st_cap_q[63:32];
                2'd3: lane_in = st_cap_q[31:0];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_kw_d = last_kw_q;
        st_cap_d  = st_cap_q;
        kw_cap_d  = kw_cap_q;
        st_out_d  = st_out_q;
        kw_out_d  = kw_out_q;
        st_ov_d   = 1'b0;
        kw_ov_d   = 1'b0;
        grant_st  = 1'b0;
        grant_kw  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Readies are held low while rst is asserted so nothing is
                // accepted before the first cycle after reset releases.
                if (!rst) begin
                    grant_kw = bus.kw_valid && (!bus.st_valid || !last_kw_q);
                    grant_st = bus.st_valid && !grant_kw;
                end
                if (grant_st) begin
                    state_d   = ST_PASS;
                    cnt_d     = 2'd0;
                    st_cap_d  = bus.st_data;
                    last_kw_d = 1'b0;
                end else if (grant_kw) begin
                    state_d   = KW_PASS;
                    kw_cap_d  = bus.kw_data;
                    last_kw_d = 1'b1;
                end
            end
            ST_PASS: begin
                unique case (cnt_q)
                    2'd0: st_out_d[127:96] = lane_out;
                    2'd1: st_out_d[95:64]  = lane_out;
                    2'd2: st_out_d[63:32]  = lane_out;
                    2'd3: st_out_d[31:0]   = lane_out;
                endcase
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                    st_ov_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            KW_PASS: begin
                kw_out_d = lane_out;
                kw_ov_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            last_kw_q <= 1'b0;
            st_cap_q  <= '0;
            kw_cap_q  <= '0;
            st_out_q  <= '0;
            kw_out_q  <= '0;
            st_ov_q   <= 1'b0;
            kw_ov_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_kw_q <= last_kw_d;
            st_cap_q  <= st_cap_d;
            kw_cap_q  <= kw_cap_d;
            st_out_q  <= st_out_d;
            kw_out_q  <= kw_out_d;
            st_ov_q   <= st_ov_d;
            kw_ov_q   <= kw_ov_d;
        end
    end

    assign bus.st_ready     = grant_st;
    assign bus.kw_ready     = grant_kw;
    assign bus.st_out_valid = st_ov_q;
    assign bus.st_out_data  = st_out_q;
    assign bus.kw_out_valid = kw_ov_q;
    assign bus.kw_out_data  = kw_out_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: doc/sbox_share_ctrl.md
SBOX_SHARE_CTRL -- requirements
Module: sbox_share_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on rising clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 st_valid  in  1  state SubBytes request.
REQ-005 st_ready  out  1  state request accepted when st_valid&&st_ready.
REQ-006 st_data  in  128  AES state in; byte 15 = bits[127:120].
REQ-007 kw_valid  in  1  key-schedule SubWord request.
REQ-008 kw_ready  out  1  key request accepted when kw_valid&&kw_ready.
REQ-009 kw_data  in  32  key word in.
REQ-010 st_out_valid  out  1  one-cycle pulse; st_out_data is valid.
REQ-011 st_out_data  out  128  SubBytes(st_data).
REQ-012 kw_out_valid  out  1  one-cycle pulse; kw_out_data is valid.
REQ-013 kw_out_data  out  32  SubWord(kw_data).
REQ-014 busy  out  1  high when state != IDLE.

Function
REQ-015 Block SHALL own exactly one 32-bit S-box lane (4 byte S-boxes, FIPS-197 forward table) shared by both requesters.
REQ-016 FSM states SHALL be IDLE, ST_PASS, KW_PASS.
REQ-017 st_ready and kw_ready SHALL be high only in IDLE, and only for the requester the arbiter would grant that cycle.
REQ-018 Arbitration SHALL be round-robin: with both valid in IDLE, grant the requester not granted last; with one valid, grant it. Pointer "last" resets to ST, so key wins first.
REQ-019 On acceptance, input data SHALL be captured into an internal register; later input changes SHALL have no effect.
REQ-020 ST_PASS SHALL process one 32-bit word per cycle, word counter 0..3; word 0 = bits[127:96], word 3 = bits[31:0]; each result SHALL be written into the matching st_out_data slice at the clock edge.
REQ-021 After word 3, FSM SHALL return to IDLE and pulse st_out_valid for exactly the next cycle.
REQ-022 Latency: acceptance in cycle 0 -> st_out_valid in cycle 5; kw accept in cycle 0 -> KW_PASS in cycle 1 -> kw_out_valid in cycle 2.
REQ-023 A new request SHALL be acceptable in the same cycle as the previous output pulse (back-to-back).
REQ-024 Throughput: one state per 5 cycles; one key word per 2 cycles.
REQ-025 st_out_data and kw_out_data SHALL hold their last value until overwritten by a later pass.
REQ-026 st_out_data slices SHALL be updated progressively during ST_PASS; only the value during the valid pulse is defined.
REQ-027 Counter SHALL be 2 bits; it resets to 0 on entering ST_PASS and SHALL NOT wrap past 3 while in that state.

Reset
REQ-028 rst SHALL force IDLE, counter 0, arbiter pointer = ST, st_out_valid=0, kw_out_valid=0, st_out_data=0, kw_out_data=0.
REQ-029 rst mid-pass SHALL abort the pass with no output pulse; requests held during reset SHALL NOT be accepted until the first cycle after rst deasserts.

Structure
REQ-030 Shared package aes_pkg SHALL hold the 256-entry S-box constant, the FSM state enum, and width constants (STATE_W=128, WORD_W=32).
REQ-031 The S-box lane SHALL be a single sub-module, sbox_lane32: 32-bit in, 32-bit out, combinational, indexing aes_pkg's table.

Verification
REQ-032 st_data=0x00112233445566778899aabbccddeeff accepted in cycle 0 -> st_out_valid in cycle 5 only, st_out_data=0x638293c31bfc33f5c4eeacea4bc12816.
REQ-033 kw_data=0xcf4f3c09 accepted -> kw_out_valid 2 cycles later, kw_out_data=0x8a84eb01.
REQ-034 Both valid continuously after reset -> grants alternate KW, ST, KW, ST; no lost or duplicated pulses; ready never high outside IDLE.
REQ-035 Byte spot check: kw_data=0x0001_53ff -> 0x637ced16.
REQ-036 rst asserted in cycle 2 of an ST pass -> no st_out_valid; busy=0 and outputs zero the next cycle; the next request completes normally.
REQ-037 Back-to-back ST requests with st_data changed while busy -> each output matches the value captured at its acceptance; second accepted in the first's pulse cycle.
